set_assoc_cache: RTL and testbench
==================================

Name: set_assoc_cache

Overview:
Parametrised N-way set-associative cache controller between a simple CPU request port and a word-addressed backing RAM. It generalises the existing 2-way, 8-set, 8-bit cache with configurable ways, sets, tag and data widths, and a selectable write policy (write-through or write-back). It adds true LRU replacement, a valid/ready request handshake, a variable-latency memory handshake and saturating hit/miss counters. Tag, data, valid, dirty and age state are held in internal registers; one line holds one word.

Parameters:
ADDR_W, 5, CPU/RAM word address width.
INDEX_W, 3, set index width (2**INDEX_W sets); TAG_W = ADDR_W - INDEX_W.
DATA_W, 8, data word width.
WAYS, 2, associativity; legal values 1, 2 or 4.
WRITE_BACK, 0, 0 = write-through, no-write-allocate; 1 = write-back, write-allocate.
CNT_W, 16, width of each statistics counter.

Ports:
clock  in  1  rising-edge clock
reset  in  1  reset, synchronous, active-high
req_valid  in  1  CPU request present
req_ready  out  1  controller accepts a request (high only in IDLE)
req_we  in  1  1 = write, 0 = read
req_addr  in  ADDR_W  word address: tag = [ADDR_W-1:INDEX_W], index = [INDEX_W-1:0]
req_wdata  in  DATA_W  write data
resp_valid  out  1  one-cycle response pulse
resp_rdata  out  DATA_W  read data (writes return the written word)
resp_hit  out  1  request hit in the cache
mem_req  out  1  memory request, held until mem_ack
mem_we  out  1  memory write
mem_addr  out  ADDR_W  memory word address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  read data, valid when mem_ack=1
mem_ack  in  1  one-cycle completion pulse
hit_count  out  CNT_W  saturating hit counter
miss_count  out  CNT_W  saturating miss counter

Behaviour:
- Reset values: all valid, dirty and age bits cleared, all outputs 0 except req_ready=1, state=IDLE. Tag and data arrays are not cleared.
- Reset mid-operation: the next edge forces IDLE and drops mem_req. The in-flight request is discarded with no response.
- Request capture:
  - IDLE: req_valid && req_ready at edge N latches we/addr/wdata; state goes to LOOKUP.
  - req_valid is ignored outside IDLE.
- LOOKUP (cycle N+1): compare the tag against all valid ways of the set. A hit requires exactly one match; more than one match is illegal (assertion).
- Read hit: RESP in N+2 with resp_valid=1, resp_hit=1, data from the hit way. IDLE in N+3.
- Read miss:
  - Choose the victim.
  - If WRITE_BACK=1 and the victim is valid and dirty: EVICT, with mem_we=1, mem_addr={victim_tag,index}, mem_wdata=victim data, held until mem_ack.
  - Then REFILL: mem_req=1, mem_we=0, mem_addr=req_addr.
  - On mem_ack, write the line (valid=1, dirty=0, tag), then RESP with resp_hit=0 and resp_rdata=mem_rdata.
- Write, WRITE_BACK=0:
  - Hit: update the line and go to a WRITE state that issues a memory write of req_wdata, held until ack.
  - Miss: memory write only, no allocate.
  - In both cases RESP follows the ack.
- Write, WRITE_BACK=1:
  - Hit: update data, set dirty, RESP in N+2.
  - Miss: EVICT if needed, then REFILL, then merge the write (dirty=1), then RESP.
  - No memory write on a hit.
- FSM states: IDLE, LOOKUP, EVICT, REFILL, WRITE, RESP. mem_req is asserted only in EVICT, REFILL and WRITE. Each of these exits only on mem_ack; a mem_ack arriving in any other state is ignored.
- LRU ages:
  - Each way has a log2(WAYS)-bit age per set.
  - On every hit or fill, the accessed way's age becomes 0, and ways whose age is less than its old age increment.
  - After reset, ages of invalid ways are irrelevant.
  - Victim = lowest-index invalid way, else the way with age WAYS-1.
  - WAYS=1: there is no age state and the victim is always way 0.
  - A write-through write miss does not touch LRU.
- Counters:
  - Increment in LOOKUP: hit_count on a hit, miss_count on a miss.
  - Saturate at 2**CNT_W-1.
  - Cleared only by reset.
- resp_rdata holds its value until the next RESP.

Decomposition:
- Package cache_pkg: FSM state enum, a TAG_W helper function, and a legal-WAYS check.
- One sub-module, cache_lru: one set's age update and victim select.
  - Inputs: ages, valid vector, access way, access strobe.
  - Outputs: next ages, victim way.
  - Instantiated once and muxed by index.

Test Plan:
1. Reset, then read 0x05 with mem_rdata=0xA5 and ack 3 cycles after mem_req → miss, resp_rdata=0xA5, resp_hit=0, miss_count=1. A repeat read → resp_valid 2 cycles after accept, resp_hit=1, 0xA5, hit_count=1.
2. WAYS=2: reads 0x05 (tag 0), 0x0D (tag 1), 0x05, then 0x15 (tag 2) → the 0x15 fill evicts 0x0D's way. A re-read of 0x05 hits; a re-read of 0x0D misses.
3. WRITE_BACK=0: write 0x3C to 0x02 on a cold cache → one mem write (addr 0x02, data 0x3C) and no allocate; a following read of 0x02 misses.
4. WRITE_BACK=1: fill 0x01 and 0x09, write 0x77 to 0x01, then read 0x11 and 0x19 → EVICT write of 0x77 to 0x01 precedes the refill. The clean line is evicted without a memory write.
5. Assert reset while in REFILL with mem_req=1 → mem_req=0, req_ready=1 after the edge, no resp_valid. A subsequent read of the same address misses.
6. Force hit_count to 0xFFFE with CNT_W=16 and issue 3 hits → hit_count sticks at 0xFFFF.

Source files
------------

// File: rtl/set_assoc_cache_pkg.sv
// Shared types and elaboration helpers for the set-associative cache.
package cache_pkg;

  typedef enum logic [2:0] {IDLE, LOOKUP, EVICT, REFILL, WRITE, RESP} cacheState_t;

  function automatic int tagWidth(input int addrW, input int indexW);
    return addrW - indexW;
  endfunction

  function automatic int wayWidth(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

  function automatic bit waysLegal(input int ways);
    return (ways == 1) || (ways == 2) || (ways == 4);
  endfunction

endpackage

// File: rtl/set_assoc_cache_if.sv
// CPU request/response port and backing-RAM port of the cache, bundled together.
interface set_assoc_cache_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_hit;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, mem_rdata, mem_ack,
    input  req_ready, resp_valid, resp_rdata, resp_hit,
           mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, mem_rdata, mem_ack,
    output req_ready, resp_valid, resp_rdata, resp_hit,
           mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/set_assoc_cache_lru.sv
// True-LRU age update and victim selection for a single cache set.
module cache_lru
  import cache_pkg::*;
#(
  parameter int WAYS = 2,
  localparam int WAY_W = wayWidth(WAYS)
)(
  input  logic [WAYS-1:0][WAY_W-1:0] ages_i,
  input  logic [WAYS-1:0]            valid_i,
  input  logic [WAY_W-1:0]           accessWay_i,
  input  logic                       access_i,
  output logic [WAYS-1:0][WAY_W-1:0] agesNext_o,
  output logic [WAY_W-1:0]           victim_o
);

  localparam logic [WAY_W-1:0] OLDEST = WAY_W'(WAYS - 1);

  logic [WAY_W-1:0] oldAge;
  logic             anyInvalid;

  // Filling an invalid way counts as touching the oldest slot, so ages stay a permutation.
  always_comb begin
    oldAge     = valid_i[accessWay_i] ? ages_i[accessWay_i] : OLDEST;
    agesNext_o = ages_i;
    if (access_i && (WAYS > 1)) begin
      for (int w = 0; w < WAYS; w++) begin
        if (WAY_W'(w) == accessWay_i) begin
          agesNext_o[w] = '0;
        end else if (ages_i[w] < oldAge) begin
          agesNext_o[w] = ages_i[w] + WAY_W'(1);
        end
      end
    end
  end

  always_comb begin
    victim_o   = '0;
    anyInvalid = 1'b0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_i[w]) begin
        victim_o   = WAY_W'(w);
        anyInvalid = 1'b1;
      end
    end
    if (!anyInvalid) begin
      for (int w = 0; w < WAYS; w++) begin
        if (ages_i[w] == OLDEST) victim_o = WAY_W'(w);
      end
    end
  end

endmodule

// File: rtl/set_assoc_cache.sv
// N-way set-associative cache controller with LRU replacement and a selectable write policy.
module set_assoc_cache
  import cache_pkg::*;
#(
  parameter int ADDR_W     = 5,
  parameter int INDEX_W    = 3,
  parameter int DATA_W     = 8,
  parameter int WAYS       = 2,
  parameter int WRITE_BACK = 0,
  parameter int CNT_W      = 16
)(
  input  logic             clock,
  input  logic             reset,
  set_assoc_cache_if.slave bus,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);

  localparam int TAG_W = tagWidth(ADDR_W, INDEX_W);
  localparam int SETS  = 1 << INDEX_W;
  localparam int WAY_W = wayWidth(WAYS);

  if (!waysLegal(WAYS)) begin : gWaysCheck
    $error("set_assoc_cache: WAYS must be 1, 2 or 4");
  end

  cacheState_t state_q, state_d;

  logic                       we_q;
  logic [ADDR_W-1:0]          addr_q;
  logic [DATA_W-1:0]          wdata_q;
  logic [TAG_W-1:0]           tag_q   [SETS][WAYS];
  logic [DATA_W-1:0]          data_q  [SETS][WAYS];
  logic [WAYS-1:0]            valid_q [SETS];
  logic [WAYS-1:0]            dirty_q [SETS];
  logic [WAYS-1:0][WAY_W-1:0] age_q   [SETS];
  logic [WAY_W-1:0]           victimWay_q;
  logic                       hitFlag_q;
  logic                       respHit_q;
  logic [DATA_W-1:0]          respRdata_q;
  logic [CNT_W-1:0]           hitCount_q;
  logic [CNT_W-1:0]           missCount_q;

  logic [INDEX_W-1:0]         index;
  logic [TAG_W-1:0]           reqTag;
  logic [WAYS-1:0]            matchVec;
  logic                       hit;
  logic [WAY_W-1:0]           hitWay;
  logic                       needEvict;
  logic                       lruAccess;
  logic [WAY_W-1:0]           lruWay;
  logic [WAY_W-1:0]           lruVictim;
  logic [WAYS-1:0][WAY_W-1:0] agesNext;
  logic [DATA_W-1:0]          respData;

  assign index  = addr_q[INDEX_W-1:0];
  assign reqTag = addr_q[ADDR_W-1:INDEX_W];

  always_comb begin
    matchVec = '0;
    hitWay   = '0;
    for (int w = 0; w < WAYS; w++) begin
      matchVec[w] = valid_q[index][w] && (tag_q[index][w] == reqTag);
      if (matchVec[w]) hitWay = WAY_W'(w);
    end
  end

  assign hit       = |matchVec;
  assign needEvict = (WRITE_BACK != 0) && valid_q[index][lruVictim] && dirty_q[index][lruVictim];
  assign lruAccess = ((state_q == LOOKUP) && hit) || ((state_q == REFILL) && bus.mem_ack);
  assign lruWay    = (state_q == LOOKUP) ? hitWay : victimWay_q;
  assign respData  = we_q ? wdata_q : ((state_q == REFILL) ? bus.mem_rdata : data_q[index][hitWay]);

  cache_lru #(.WAYS(WAYS)) uLru (
    .ages_i      (age_q[index]),
    .valid_i     (valid_q[index]),
    .accessWay_i (lruWay),
    .access_i    (lruAccess),
    .agesNext_o  (agesNext),
    .victim_o    (lruVictim)
  );

  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.req_valid) state_d = LOOKUP;
      LOOKUP: begin
        if (we_q && (WRITE_BACK == 0)) state_d = WRITE;
        else if (hit)                  state_d = RESP;
        else if (needEvict)            state_d = EVICT;
        else                           state_d = REFILL;
      end
      EVICT:   if (bus.mem_ack) state_d = REFILL;
      REFILL:  if (bus.mem_ack) state_d = RESP;
      WRITE:   if (bus.mem_ack) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready  = (state_q == IDLE);
    bus.resp_valid = (state_q == RESP);
    bus.mem_req    = (state_q == EVICT) || (state_q == REFILL) || (state_q == WRITE);
    bus.mem_we     = (state_q == EVICT) || (state_q == WRITE);
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;
    case (state_q)
      EVICT: begin
        bus.mem_addr  = {tag_q[index][victimWay_q], index};
        bus.mem_wdata = data_q[index][victimWay_q];
      end
      REFILL: bus.mem_addr = addr_q;
      WRITE: begin
        bus.mem_addr  = addr_q;
        bus.mem_wdata = wdata_q;
      end
      default: ;
    endcase
  end

  assign bus.resp_rdata = respRdata_q;
  assign bus.resp_hit   = respHit_q;
  assign hit_count      = hitCount_q;
  assign miss_count     = missCount_q;

  // Tag/data arrays and the captured request are never reset; valid bits gate them.
  always_ff @(posedge clock) begin
    if ((state_q == IDLE) && bus.req_valid) begin
      we_q    <= bus.req_we;
      addr_q  <= bus.req_addr;
      wdata_q <= bus.req_wdata;
    end
    if ((state_q == LOOKUP) && hit && we_q) data_q[index][hitWay] <= wdata_q;
    if ((state_q == REFILL) && bus.mem_ack) begin
      tag_q[index][victimWay_q]  <= reqTag;
      data_q[index][victimWay_q] <= ((WRITE_BACK != 0) && we_q) ? wdata_q : bus.mem_rdata;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        age_q[s]   <= '0;
      end
      victimWay_q <= '0;
      hitFlag_q   <= 1'b0;
      respHit_q   <= 1'b0;
      respRdata_q <= '0;
      hitCount_q  <= '0;
      missCount_q <= '0;
    end else begin
      if (lruAccess) age_q[index] <= agesNext;
      if (state_q == LOOKUP) begin
        hitFlag_q   <= hit;
        victimWay_q <= lruVictim;
        if (hit) begin
          if (hitCount_q != '1) hitCount_q <= hitCount_q + CNT_W'(1);
        end else if (missCount_q != '1) begin
          missCount_q <= missCount_q + CNT_W'(1);
        end
        if (hit && we_q && (WRITE_BACK != 0)) dirty_q[index][hitWay] <= 1'b1;
      end
      if ((state_q == REFILL) && bus.mem_ack) begin
        valid_q[index][victimWay_q] <= 1'b1;
        dirty_q[index][victimWay_q] <= (WRITE_BACK != 0) && we_q;
      end
      if ((state_d == RESP) && (state_q != RESP)) begin
        respRdata_q <= respData;
        respHit_q   <= (state_q == LOOKUP) ? hit : hitFlag_q;
      end
    end
  end

  assert property (@(posedge clock) disable iff (reset) (state_q == LOOKUP) |-> $onehot0(matchVec));

endmodule

// File: tb/tb_set_assoc_cache.sv
// Directed bench: a write-through instance and a write-back instance with tiny counters.
module tb_set_assoc_cache;

  logic       clock    = 1'b0;
  logic       reset    = 1'b1;
  logic       sel      = 1'b0;
  logic       reqValid = 1'b0;
  logic       reqWe    = 1'b0;
  logic [4:0] reqAddr  = '0;
  logic [7:0] reqWdata = '0;
  logic       respValid;
  logic       respHit;
  logic [7:0] respRdata;
  logic [15:0] hitCnt0, missCnt0;
  logic [1:0]  hitCnt1, missCnt1;
  int checks = 0;
  int passes = 0;
  logic [7:0] rdVal;
  logic       hitVal;
  int latVal;
  int logStart;
  int respSeen;

  always #5 clock = ~clock;

  set_assoc_cache_if #(.ADDR_W(5), .DATA_W(8)) cacheBus [2] ();

  assign cacheBus[0].req_valid = reqValid && !sel;
  assign cacheBus[1].req_valid = reqValid && sel;
  assign cacheBus[0].req_we    = reqWe;
  assign cacheBus[1].req_we    = reqWe;
  assign cacheBus[0].req_addr  = reqAddr;
  assign cacheBus[1].req_addr  = reqAddr;
  assign cacheBus[0].req_wdata = reqWdata;
  assign cacheBus[1].req_wdata = reqWdata;
  assign respValid = sel ? cacheBus[1].resp_valid : cacheBus[0].resp_valid;
  assign respHit   = sel ? cacheBus[1].resp_hit   : cacheBus[0].resp_hit;
  assign respRdata = sel ? cacheBus[1].resp_rdata : cacheBus[0].resp_rdata;

  set_assoc_cache #(.ADDR_W(5), .INDEX_W(3), .DATA_W(8), .WAYS(2), .WRITE_BACK(0), .CNT_W(16)) dutWt (
    .clock(clock), .reset(reset), .bus(cacheBus[0]), .hit_count(hitCnt0), .miss_count(missCnt0));

  set_assoc_cache #(.ADDR_W(5), .INDEX_W(3), .DATA_W(8), .WAYS(2), .WRITE_BACK(1), .CNT_W(2)) dutWb (
    .clock(clock), .reset(reset), .bus(cacheBus[1]), .hit_count(hitCnt1), .miss_count(missCnt1));

  // Backing RAM per instance: word i resets to i^0xA0, acks 3 cycles after mem_req, logs every access.
  for (genvar g = 0; g < 2; g++) begin : gMem
    logic [7:0] mem [32];
    logic       ack = 1'b0;
    int         ackDelay = 0;
    int         logN = 0;
    logic       logWe   [64];
    logic [4:0] logAddr [64];
    logic [7:0] logData [64];

    assign cacheBus[g].mem_ack   = ack;
    assign cacheBus[g].mem_rdata = mem[cacheBus[g].mem_addr];

    always @(posedge clock) begin
      ack <= 1'b0;
      if (reset) begin
        ackDelay <= 0;
        for (int i = 0; i < 32; i++) mem[i] <= 8'(i) ^ 8'hA0;
      end else if (cacheBus[g].mem_req && !ack) begin
        if (ackDelay == 2) begin
          ack      <= 1'b1;
          ackDelay <= 0;
          logWe[logN % 64]   <= cacheBus[g].mem_we;
          logAddr[logN % 64] <= cacheBus[g].mem_addr;
          logData[logN % 64] <= cacheBus[g].mem_wdata;
          logN <= logN + 1;
          if (cacheBus[g].mem_we) mem[cacheBus[g].mem_addr] <= cacheBus[g].mem_wdata;
        end else begin
          ackDelay <= ackDelay + 1;
        end
      end else begin
        ackDelay <= 0;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
  endtask

  task automatic applyStimulus(input bit which, input bit we, input logic [4:0] addr,
                               input logic [7:0] wdata, input string tag);
    @(negedge clock);
    sel      = which;
    reqWe    = we;
    reqAddr  = addr;
    reqWdata = wdata;
    reqValid = 1'b1;
    @(posedge clock);
    #1 reqValid = 1'b0;
    latVal = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clock);
      latVal++;
      if (respValid) break;
    end
    checkOutput({tag, "/respValid"}, respValid, 1);
    rdVal  = respRdata;
    hitVal = respHit;
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clock);
    reset = 1'b0;
    checkOutput("rstReady", cacheBus[0].req_ready, 1);
    checkOutput("rstRespValid", cacheBus[0].resp_valid, 0);
    checkOutput("rstMemReq", cacheBus[0].mem_req, 0);
    checkOutput("rstRdata", cacheBus[0].resp_rdata, 0);
    checkOutput("rstHitCnt", hitCnt0, 0);
    checkOutput("rstMissCnt", missCnt0, 0);

    // Cold read miss, then the repeat hits with 2-cycle latency.
    applyStimulus(0, 0, 5'h05, 8'h00, "t1Miss");
    checkOutput("t1MissData", rdVal, 8'hA5);
    checkOutput("t1MissHit", hitVal, 0);
    checkOutput("t1MissLat", latVal, 6);
    checkOutput("t1MissCnt", missCnt0, 1);
    checkOutput("t1RefillAddr", gMem[0].logAddr[0], 5'h05);
    checkOutput("t1RefillWe", gMem[0].logWe[0], 0);
    applyStimulus(0, 0, 5'h05, 8'h00, "t1Hit");
    checkOutput("t1HitData", rdVal, 8'hA5);
    checkOutput("t1HitHit", hitVal, 1);
    checkOutput("t1HitLat", latVal, 2);
    checkOutput("t1HitCnt", hitCnt0, 1);

    // LRU: 0x15 must evict 0x0D, leaving 0x05 resident.
    applyStimulus(0, 0, 5'h0D, 8'h00, "t2Rd0D");
    checkOutput("t2Rd0DHit", hitVal, 0);
    checkOutput("t2Rd0DData", rdVal, 8'hAD);
    applyStimulus(0, 0, 5'h05, 8'h00, "t2Rd05");
    checkOutput("t2Rd05Hit", hitVal, 1);
    applyStimulus(0, 0, 5'h15, 8'h00, "t2Rd15");
    checkOutput("t2Rd15Hit", hitVal, 0);
    checkOutput("t2Rd15Data", rdVal, 8'hB5);
    applyStimulus(0, 0, 5'h05, 8'h00, "t2Re05");
    checkOutput("t2Re05Hit", hitVal, 1);
    applyStimulus(0, 0, 5'h0D, 8'h00, "t2Re0D");
    checkOutput("t2Re0DHit", hitVal, 0);
    checkOutput("t2HitCnt", hitCnt0, 3);
    checkOutput("t2MissCnt", missCnt0, 4);

    // Write-through: write miss goes to memory only; write hit updates both.
    logStart = gMem[0].logN;
    applyStimulus(0, 1, 5'h02, 8'h3C, "t3WrMiss");
    checkOutput("t3WrMissHit", hitVal, 0);
    checkOutput("t3WrMissData", rdVal, 8'h3C);
    checkOutput("t3WrMissCount", gMem[0].logN - logStart, 1);
    checkOutput("t3WrMissWe", gMem[0].logWe[logStart], 1);
    checkOutput("t3WrMissAddr", gMem[0].logAddr[logStart], 5'h02);
    checkOutput("t3WrMissWdata", gMem[0].logData[logStart], 8'h3C);
    applyStimulus(0, 0, 5'h02, 8'h00, "t3Rd02");
    checkOutput("t3Rd02Hit", hitVal, 0);
    checkOutput("t3Rd02Data", rdVal, 8'h3C);
    logStart = gMem[0].logN;
    applyStimulus(0, 1, 5'h05, 8'h5A, "t3WrHit");
    checkOutput("t3WrHitHit", hitVal, 1);
    checkOutput("t3WrHitCount", gMem[0].logN - logStart, 1);
    checkOutput("t3WrHitWdata", gMem[0].logData[logStart], 8'h5A);
    applyStimulus(0, 0, 5'h05, 8'h00, "t3Rd05");
    checkOutput("t3Rd05Hit", hitVal, 1);
    checkOutput("t3Rd05Data", rdVal, 8'h5A);
    checkOutput("t3HitCnt", hitCnt0, 5);
    checkOutput("t3MissCnt", missCnt0, 6);

    // Write-back: dirty victim is written back before the refill, clean victim silently dropped.
    applyStimulus(1, 0, 5'h01, 8'h00, "t4Rd01");
    checkOutput("t4Rd01Data", rdVal, 8'hA1);
    applyStimulus(1, 0, 5'h09, 8'h00, "t4Rd09");
    checkOutput("t4Rd09Data", rdVal, 8'hA9);
    logStart = gMem[1].logN;
    applyStimulus(1, 1, 5'h01, 8'h77, "t4Wr01");
    checkOutput("t4Wr01Hit", hitVal, 1);
    checkOutput("t4Wr01Lat", latVal, 2);
    checkOutput("t4Wr01NoMem", gMem[1].logN - logStart, 0);
    logStart = gMem[1].logN;
    applyStimulus(1, 0, 5'h11, 8'h00, "t4Rd11");
    checkOutput("t4Rd11Data", rdVal, 8'hB1);
    checkOutput("t4Rd11Count", gMem[1].logN - logStart, 1);
    checkOutput("t4Rd11We", gMem[1].logWe[logStart], 0);
    logStart = gMem[1].logN;
    applyStimulus(1, 0, 5'h19, 8'h00, "t4Rd19");
    checkOutput("t4Rd19Data", rdVal, 8'hB9);
    checkOutput("t4Rd19Count", gMem[1].logN - logStart, 2);
    checkOutput("t4EvictWe", gMem[1].logWe[logStart], 1);
    checkOutput("t4EvictAddr", gMem[1].logAddr[logStart], 5'h01);
    checkOutput("t4EvictData", gMem[1].logData[logStart], 8'h77);
    checkOutput("t4RefillWe", gMem[1].logWe[logStart + 1], 0);
    checkOutput("t4RefillAddr", gMem[1].logAddr[logStart + 1], 5'h19);
    applyStimulus(1, 0, 5'h01, 8'h00, "t4Re01");
    checkOutput("t4Re01Hit", hitVal, 0);
    checkOutput("t4Re01Data", rdVal, 8'h77);

    // Saturation of 2-bit counters: hits 1->2->3->3, misses already past 3.
    applyStimulus(1, 0, 5'h19, 8'h00, "t6Hit1");
    checkOutput("t6Hit1Hit", hitVal, 1);
    applyStimulus(1, 0, 5'h01, 8'h00, "t6Hit2");
    checkOutput("t6Hit2Cnt", hitCnt1, 3);
    applyStimulus(1, 0, 5'h19, 8'h00, "t6Hit3");
    checkOutput("t6HitSat", hitCnt1, 3);
    checkOutput("t6MissSat", missCnt1, 3);

    // Reset in the middle of a refill drops the request without a response.
    @(negedge clock);
    sel      = 1'b0;
    reqWe    = 1'b0;
    reqAddr  = 5'h1F;
    reqValid = 1'b1;
    @(posedge clock);
    #1 reqValid = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      if (cacheBus[0].mem_req) break;
    end
    checkOutput("t5MemReqUp", cacheBus[0].mem_req, 1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    checkOutput("t5MemReqDrop", cacheBus[0].mem_req, 0);
    checkOutput("t5Ready", cacheBus[0].req_ready, 1);
    checkOutput("t5RespValid", cacheBus[0].resp_valid, 0);
    respSeen = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      if (cacheBus[0].resp_valid) respSeen++;
    end
    checkOutput("t5NoResp", respSeen, 0);
    checkOutput("t5HitCntClr", hitCnt0, 0);
    checkOutput("t5MissCntClr", missCnt0, 0);
    applyStimulus(0, 0, 5'h1F, 8'h00, "t5Rd1F");
    checkOutput("t5Rd1FHit", hitVal, 0);
    checkOutput("t5Rd1FData", rdVal, 8'hBF);
    checkOutput("t5MissCnt", missCnt0, 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
